// File: rtl/mux_rr_sched.sv
// mux_rr_sched: 4-lane round-robin scheduler, per-lane FIFOs drained one word per clock.
// Define MUX_RR_DROPCNT_EN to add the saturating per-lane drop_cnt output.
module mux_rr_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [WIDTH-1:0] Entrada3,
  input  logic             validEntrada0,
  input  logic             validEntrada1,
  input  logic             validEntrada2,
  input  logic             validEntrada3,
  output logic [WIDTH-1:0] Salida,
  output logic             validsalida,
  output logic [1:0]       lane_id,
  output logic [3:0]       overflow,
  output logic             busy
`ifdef MUX_RR_DROPCNT_EN
  , output logic [31:0]    drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SERVE} state_t;
  state_t           state;
  logic [1:0]       rr_ptr, grant, idx;
  logic             grant_vld, pop;
  logic [WIDTH-1:0] din [4];
  logic [WIDTH-1:0] head [4];
  logic [3:0]       vin, nonempty, nxt_nonempty;
  assign din  = '{Entrada0, Entrada1, Entrada2, Entrada3};
  assign vin  = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};
  assign busy = |nonempty;
  // Scan from the farthest candidate down so the nearest non-empty lane after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    idx       = rr_ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_ptr + 2'(i);
      if (nonempty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end
  assign pop = (state == SERVE) && en && grant_vld && !flush;
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             push, pop_l, drop, ovf;
    assign pop_l           = pop && (grant == 2'(g));
    // A full lane still accepts when its head leaves on the same edge.
    assign push            = vin[g] && !flush && ((cnt != CW'(DEPTH)) || pop_l);
    assign drop            = vin[g] && !flush && !push;
    assign cnt_nxt         = cnt + CW'(push) - CW'(pop_l);
    assign nonempty[g]     = cnt != '0;
    assign nxt_nonempty[g] = cnt_nxt != '0;
    assign head[g]         = mem[rd_ptr];
    assign overflow[g]     = ovf;
    always_ff @(posedge clk_f) begin
      if (push) mem[wr_ptr] <= din[g];
    end
    always_ff @(posedge clk_f or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop_l) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt_nxt;
        if (drop) ovf <= 1'b1;
      end
    end
`ifdef MUX_RR_DROPCNT_EN
    logic [7:0] dcnt;
    assign drop_cnt[8*g +: 8] = dcnt;
    always_ff @(posedge clk_f or negedge reset) begin
      if (!reset) dcnt <= '0;
      else if (flush) dcnt <= '0;
      else if (drop && dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
    end
`endif
  end
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      Salida      <= '0;
      validsalida <= 1'b0;
      lane_id     <= 2'd0;
      rr_ptr      <= 2'd3;
      state       <= IDLE;
    end else if (flush) begin
      validsalida <= 1'b0;
      state       <= IDLE;
    end else begin
      validsalida <= pop;
      if (pop) begin
        Salida  <= head[grant];
        lane_id <= grant;
        rr_ptr  <= grant;
      end
      state <= (state == IDLE) ? ((en && busy) ? SERVE : IDLE)
                               : ((en && |nxt_nonempty) ? SERVE : IDLE);
    end
  end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: scenario tasks with a per-lane scoreboard checked by an output monitor.
module tb_mux_rr_sched;
  logic        clk_f = 1'b0, reset = 1'b0, en = 1'b0, flush = 1'b0;
  logic [7:0]  e [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic [3:0]  v = 4'h0;
  logic [7:0]  Salida;
  logic        validsalida, busy;
  logic [1:0]  lane_id;
  logic [3:0]  overflow;
  logic [31:0] drop_cnt;
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  sbq [4][$];
  logic [7:0]  mon_exp;

  always #5 clk_f = ~clk_f;

  mux_rr_sched #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_f(clk_f), .reset(reset), .en(en), .flush(flush),
    .Entrada0(e[0]), .Entrada1(e[1]), .Entrada2(e[2]), .Entrada3(e[3]),
    .validEntrada0(v[0]), .validEntrada1(v[1]), .validEntrada2(v[2]), .validEntrada3(v[3]),
    .Salida(Salida), .validsalida(validsalida), .lane_id(lane_id),
    .overflow(overflow), .busy(busy)
`ifdef MUX_RR_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
`ifndef MUX_RR_DROPCNT_EN
  assign drop_cnt = '0;
`endif

  always @(negedge clk_f) begin
    if (mon_en && reset && validsalida) begin
      checks++;
      if (sbq[lane_id].size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected lane=%0d got=%h expected=none", lane_id, Salida);
      end else begin
        mon_exp = sbq[lane_id].pop_front();
        if (Salida !== mon_exp) begin
          errors++;
          $display("FAIL sb_data lane=%0d got=%h expected=%h", lane_id, Salida, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_f); v = 4'b1000; e[3] = 8'h70 + 8'(i);
    end
    @(negedge clk_f); v = 4'h0; en = 1'b1;
    checks++; if (overflow !== 4'b1000) begin errors++; $display("FAIL reset_pre_ovf got=%b expected=1000", overflow); end
    @(negedge clk_f); @(negedge clk_f);
    checks++; if (validsalida !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got=%b expected=1", validsalida); end
    #2 reset = 1'b0;
    #1;
    checks++; if (Salida !== 8'h00) begin errors++; $display("FAIL reset_salida got=%h expected=00", Salida); end
    checks++; if (validsalida !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", validsalida); end
    checks++; if (lane_id !== 2'd0) begin errors++; $display("FAIL reset_lane got=%0d expected=0", lane_id); end
    checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL reset_ovf got=%b expected=0000", overflow); end
    @(negedge clk_f); reset = 1'b1; en = 1'b0;
    foreach (sbq[l]) sbq[l].delete();
    @(negedge clk_f);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    mon_en = 1'b1;
  endtask

  task automatic test_all_lanes();
    logic [7:0] d_q[$]; logic [1:0] l_q[$]; int c_q[$];
    @(negedge clk_f); en = 1'b1; v = 4'hF; e = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int l = 0; l < 4; l++) sbq[l].push_back(e[l]);
    @(negedge clk_f); v = 4'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_f);
      if (validsalida) begin d_q.push_back(Salida); l_q.push_back(lane_id); c_q.push_back(c); end
    end
    checks++; if (d_q.size() != 4) begin errors++; $display("FAIL all_count got=%0d expected=4", d_q.size()); end
    for (int i = 0; i < 4 && i < d_q.size(); i++) begin
      checks++;
      if (l_q[i] !== 2'(i) || d_q[i] !== 8'h11 * 8'(i + 1) || c_q[i] != c_q[0] + i) begin
        errors++; $display("FAIL all_seq%0d got=%h/%0d@%0d expected=%h/%0d@%0d", i, d_q[i], l_q[i], c_q[i], 8'h11 * 8'(i + 1), i, c_q[0] + i);
      end
    end
    checks++; if (validsalida !== 1'b0) begin errors++; $display("FAIL all_tail_valid got=%b expected=0", validsalida); end
  endtask

  task automatic test_stream();
    logic [7:0] d_q[$]; logic [1:0] l_q[$]; int c_q[$];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_f);
      if (validsalida) begin d_q.push_back(Salida); l_q.push_back(lane_id); c_q.push_back(c); end
      v = (c < 6) ? 4'b0100 : 4'h0; e[2] = 8'hA0 + 8'(c);
      if (c < 6) sbq[2].push_back(e[2]);
    end
    checks++; if (d_q.size() != 6) begin errors++; $display("FAIL stream_count got=%0d expected=6", d_q.size()); end
    for (int i = 0; i < 6 && i < d_q.size(); i++) begin
      checks++;
      if (l_q[i] !== 2'd2 || d_q[i] !== 8'hA0 + 8'(i) || c_q[i] != c_q[0] + i) begin
        errors++; $display("FAIL stream_seq%0d got=%h/%0d@%0d expected=%h/2@%0d", i, d_q[i], l_q[i], c_q[i], 8'hA0 + 8'(i), c_q[0] + i);
      end
    end
    checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL stream_ovf got=%b expected=0000", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] d_q[$]; logic [1:0] l_q[$];
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_f); v = 4'b0010; e[1] = 8'(i + 1);
      if (i < 4) sbq[1].push_back(e[1]);
    end
    @(negedge clk_f); v = 4'h0;
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_flag got=%b expected=0010", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got=%b expected=1", busy); end
    checks++; if (validsalida !== 1'b0) begin errors++; $display("FAIL ovf_hold_valid got=%b expected=0", validsalida); end
`ifdef MUX_RR_DROPCNT_EN
    checks++; if (drop_cnt[15:8] !== 8'd1) begin errors++; $display("FAIL ovf_dropcnt got=%0d expected=1", drop_cnt[15:8]); end
`endif
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_f);
      if (validsalida) begin d_q.push_back(Salida); l_q.push_back(lane_id); end
    end
    checks++; if (d_q.size() != 4) begin errors++; $display("FAIL ovf_drain_count got=%0d expected=4", d_q.size()); end
    for (int i = 0; i < 4 && i < d_q.size(); i++) begin
      checks++;
      if (l_q[i] !== 2'd1 || d_q[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_drain%0d got=%h/%0d expected=%h/1", i, d_q[i], l_q[i], 8'(i + 1));
      end
    end
    @(negedge clk_f); flush = 1'b1;
    @(negedge clk_f); flush = 1'b0;
    checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL ovf_flush_clear got=%b expected=0000", overflow); end
  endtask

  task automatic test_rr_flush();
    logic [1:0] l_q[$];
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_f);
      if (validsalida) l_q.push_back(lane_id);
      if (c == 7) begin
        checks++; if (overflow !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL rr_preflush got=%b/%b expected=0000/1", overflow, busy); end
      end
      if (c == 8) begin
        checks++; if (validsalida !== 1'b0) begin errors++; $display("FAIL rr_flush_valid got=%b expected=0", validsalida); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_flush_busy got=%b expected=0", busy); end
        checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL rr_flush_ovf got=%b expected=0000", overflow); end
        foreach (sbq[l]) sbq[l].delete();
      end
      v = (c < 5) ? 4'b1001 : 4'h0; e[0] = 8'h50 + 8'(c); e[3] = 8'h30 + 8'(c);
      if (c < 5) begin sbq[0].push_back(e[0]); sbq[3].push_back(e[3]); end
      flush = (c == 7);
    end
    checks++; if (l_q.size() != 5) begin errors++; $display("FAIL rr_count got=%0d expected=5", l_q.size()); end
    for (int i = 0; i < l_q.size(); i++) begin
      checks++;
      if (!(l_q[i] == 2'd0 || l_q[i] == 2'd3) || (i > 0 && l_q[i] == l_q[i-1])) begin
        errors++; $display("FAIL rr_alt%0d got=%0d expected=other of 0/3", i, l_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d_q[$]; logic [1:0] l_q[$];
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_f); v = 4'b0001; e[0] = 8'hC0 + 8'(i); sbq[0].push_back(e[0]);
    end
    @(negedge clk_f); v = 4'h0; en = 1'b1;
    @(negedge clk_f); v = 4'b0001; e[0] = 8'hC4; sbq[0].push_back(e[0]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_f);
      if (validsalida) begin d_q.push_back(Salida); l_q.push_back(lane_id); end
      v = 4'h0;
    end
    checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL b2b_ovf got=%b expected=0000", overflow); end
    checks++; if (d_q.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d expected=5", d_q.size()); end
    for (int i = 0; i < 5 && i < d_q.size(); i++) begin
      checks++;
      if (l_q[i] !== 2'd0 || d_q[i] !== 8'hC0 + 8'(i)) begin
        errors++; $display("FAIL b2b_seq%0d got=%h/%0d expected=%h/0", i, d_q[i], l_q[i], 8'hC0 + 8'(i));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_f); v = 4'b0001; e[0] = 8'(i);
      if (i < 4) sbq[0].push_back(e[0]);
    end
    @(negedge clk_f); v = 4'h0;
    checks++; if (overflow !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL sat_flags got=%b/%b expected=0001/1", overflow, busy); end
`ifdef MUX_RR_DROPCNT_EN
    checks++; if (drop_cnt[7:0] !== 8'd255) begin errors++; $display("FAIL sat_dropcnt got=%0d expected=255", drop_cnt[7:0]); end
`endif
    flush = 1'b1;
    @(negedge clk_f); flush = 1'b0;
    foreach (sbq[l]) sbq[l].delete();
    checks++; if (busy !== 1'b0 || overflow !== 4'h0) begin errors++; $display("FAIL sat_flush got=%b/%b expected=0/0000", busy, overflow); end
`ifdef MUX_RR_DROPCNT_EN
    checks++; if (drop_cnt !== 32'h0) begin errors++; $display("FAIL sat_flush_dropcnt got=%h expected=0", drop_cnt); end
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk_f);
    reset = 1'b1;
    @(negedge clk_f);
    test_reset();
    test_all_lanes();
    test_stream();
    test_overflow();
    test_rr_flush();
    test_back_to_back();
    repeat (3) @(negedge clk_f);
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (sbq[l].size() != 0) begin errors++; $display("FAIL sb_leftover lane=%0d got=%0d expected=0", l, sbq[l].size()); end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
